// File: rtl/aes_stream_sequencer_if.sv
// aes_stream_sequencer_if
// Bundles the client stream handshake and the AES driver register bus.
//   Client request : in_valid, in_ready, in_key_load, in_key[255:0], in_block[127:0]
//   Client result  : out_valid, out_ready, out_block[127:0], out_error
//   Driver writes  : drv_data_in[31:0], drv_write_addr[3:0], drv_write_en, drv_start
//   Driver status  : drv_done, drv_read_addr[1:0], drv_data_out[31:0]
// The slave modport is the sequencer. The master modport is the client together
// with the driver it controls.
interface aes_stream_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_key_load;
  logic [255:0] in_key;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         out_error;
  logic [31:0]  drv_data_in;
  logic [3:0]   drv_write_addr;
  logic         drv_write_en;
  logic         drv_start;
  logic         drv_done;
  logic [1:0]   drv_read_addr;
  logic [31:0]  drv_data_out;

  modport slave (
    input  in_valid, in_key_load, in_key, in_block, out_ready, drv_done, drv_data_out,
    output in_ready, out_valid, out_block, out_error,
           drv_data_in, drv_write_addr, drv_write_en, drv_start, drv_read_addr
  );

  modport master (
    output in_valid, in_key_load, in_key, in_block, out_ready, drv_done, drv_data_out,
    input  in_ready, out_valid, out_block, out_error,
           drv_data_in, drv_write_addr, drv_write_en, drv_start, drv_read_addr
  );
endinterface

// File: rtl/aes_stream_sequencer.sv
// aes_stream_sequencer
// Runs one AES-256 job at a time through the register-mapped driver. A request
// (block plus an optional key) is accepted in IDLE. The sequencer writes the key
// words (when a reload is requested) and then the plaintext words. It pulses
// start, waits for done, reads the four ciphertext words back and holds the
// result until the client takes it.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high; aborts any job, clears key_valid
//   bus       : aes_stream_sequencer_if.slave (client handshake + driver bus)
//   key_valid : a key has been written to the driver since reset
//   busy      : a job is in flight (state is not IDLE)
module aes_stream_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  aes_stream_sequencer_if.slave        bus,
  output logic                         key_valid,
  output logic                         busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WKEY, S_WPT, S_START, S_WAIT, S_READ, S_OUT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done_low;
  logic               r_key_valid;
  logic [255:0]       r_key;
  logic [127:0]       r_block;
  logic [127:0]       r_out_block;
  logic               r_out_error;
  logic               w_done_ok;
  logic               w_timeout;

  // Word 0 of both the key and the block sits in the most significant bits.
  function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] i);
    return k[255 - 32*int'(i) -: 32];
  endfunction

  function automatic logic [31:0] block_word(input logic [127:0] b, input logic [1:0] i);
    return b[127 - 32*int'(i) -: 32];
  endfunction

  // A done flag counts only after it has been seen low during this WAIT.
  // This ignores a level-high done left over from the previous job.
  assign w_done_ok = r_done_low && bus.drv_done;
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.in_ready       = 1'b0;
    bus.out_valid      = 1'b0;
    bus.drv_write_en   = 1'b0;
    bus.drv_write_addr = 4'd0;
    bus.drv_data_in    = 32'd0;
    bus.drv_start      = 1'b0;
    bus.drv_read_addr  = 2'd0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_key_load)   w_next = S_WKEY;
          else if (r_key_valid)  w_next = S_WPT;
          else                   w_next = S_OUT;
        end
      end
      S_WKEY: begin
        bus.drv_write_en   = 1'b1;
        bus.drv_write_addr = {1'b0, r_idx};
        bus.drv_data_in    = key_word(r_key, r_idx);
        if (r_idx == 3'd7) w_next = S_WPT;
      end
      S_WPT: begin
        bus.drv_write_en   = 1'b1;
        bus.drv_write_addr = {2'b10, r_idx[1:0]};
        bus.drv_data_in    = block_word(r_block, r_idx[1:0]);
        if (r_idx == 3'd3) w_next = S_START;
      end
      S_START: begin
        bus.drv_start = 1'b1;
        w_next        = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ok)      w_next = S_READ;
        else if (w_timeout) w_next = S_OUT;
      end
      S_READ: begin
        bus.drv_read_addr = r_idx[1:0];
        if (r_idx == 3'd3) w_next = S_OUT;
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Captured request words are pure data and are not reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.in_valid) begin
      r_key   <= bus.in_key;
      r_block <= bus.in_block;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_done_low  <= 1'b0;
      r_key_valid <= 1'b0;
      r_out_block <= 128'd0;
      r_out_error <= 1'b0;
    end else begin
      // Word index restarts on every state change.
      r_idx <= (w_next != r_state) ? 3'd0 : r_idx + 3'd1;

      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_out_block <= 128'd0;
            r_out_error <= !bus.in_key_load && !r_key_valid;
          end
        end
        S_WKEY: begin
          if (r_idx == 3'd7) r_key_valid <= 1'b1;
        end
        S_START: begin
          r_cnt      <= '0;
          r_done_low <= 1'b0;
        end
        S_WAIT: begin
          if (!bus.drv_done) r_done_low <= 1'b1;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          if (!w_done_ok && w_timeout) begin
            r_out_block <= 128'd0;
            r_out_error <= 1'b1;
          end
        end
        S_READ: begin
          r_out_block[127 - 32*int'(r_idx[1:0]) -: 32] <= bus.drv_data_out;
          if (r_idx == 3'd3) r_out_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_block = r_out_block;
  assign bus.out_error = r_out_error;
  assign key_valid     = r_key_valid;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_stream_sequencer.sv
module tb_aes_stream_sequencer;

  localparam int TMO = 16;
  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  logic key_valid;
  logic busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  aes_stream_sequencer_if bus();

  aes_stream_sequencer #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in for the driver's cipher: the known AES-256 vector, otherwise a
  // keyed mix that still exposes wrong key or block words.
  function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] b);
    if (k == KAT_KEY && b == KAT_PT) return KAT_CT;
    return (b ^ k[255:128]) + {k[95:0], k[127:96]};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver stub ----------------
  // mode 0: done pulse, 1: done level (stale high after start), 2: stuck 0, 3: stuck 1
  int           stub_mode = 0;
  int           stub_lat  = 4;
  int           stub_stale = 1;
  int           stub_cnt;
  int           stub_stale_cnt;
  logic         stub_done;
  logic [31:0]  stub_key [8];
  logic [31:0]  stub_pt  [4];
  logic [127:0] stub_res;

  always @(posedge clk) begin
    if (reset) begin
      stub_done      <= 1'b0;
      stub_cnt       <= 0;
      stub_stale_cnt <= 0;
      stub_res       <= '0;
      for (int i = 0; i < 8; i++) stub_key[i] <= '0;
      for (int i = 0; i < 4; i++) stub_pt[i]  <= '0;
    end else begin
      if (bus.drv_write_en) begin
        if (bus.drv_write_addr < 4'd8) stub_key[bus.drv_write_addr[2:0]] <= bus.drv_data_in;
        else                           stub_pt[bus.drv_write_addr[1:0]]  <= bus.drv_data_in;
      end
      if (bus.drv_start) begin
        stub_res <= cipher({stub_key[0], stub_key[1], stub_key[2], stub_key[3],
                            stub_key[4], stub_key[5], stub_key[6], stub_key[7]},
                           {stub_pt[0], stub_pt[1], stub_pt[2], stub_pt[3]});
        stub_cnt       <= stub_lat;
        stub_stale_cnt <= stub_stale;
        if (stub_mode == 3)      stub_done <= 1'b1;
        else if (stub_mode != 1) stub_done <= 1'b0;
      end else begin
        case (stub_mode)
          2: stub_done <= 1'b0;
          3: stub_done <= 1'b1;
          default: begin
            if (stub_stale_cnt > 0) begin
              stub_stale_cnt <= stub_stale_cnt - 1;
              if (stub_stale_cnt == 1) stub_done <= 1'b0;
            end
            if (stub_cnt > 0) begin
              stub_cnt <= stub_cnt - 1;
              if (stub_cnt == 1) stub_done <= 1'b1;
            end else if (stub_mode == 0) begin
              stub_done <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.drv_done     = stub_done;
  assign bus.drv_data_out = stub_res[127 - 32*int'(bus.drv_read_addr) -: 32];

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed { logic [127:0] blk; logic err; } resp_t;
  resp_t        exp_q[$];
  logic         m_kv = 1'b0;
  logic [255:0] m_key = '0;

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1'b1, 1'b0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("result_block", bus.out_block, e.blk);
        chk("result_error", bus.out_error, e.err);
      end
    end
  end

  // One complete job: request, timing observation, optional backpressure, result handshake.
  task automatic run_job(input bit kl, input logic [255:0] key, input logic [127:0] blk,
                         input int mode, input int bp);
    int T, start_cyc, ov_cyc, d_cyc, nwr, nstart, ready_bad;
    bit seen_low, timeout_exp, nokey;
    logic [127:0] first;
    resp_t e;

    stub_mode  = mode;
    stub_stale = 1 + $urandom_range(0, 2);
    stub_lat   = stub_stale + 1 + $urandom_range(0, 7);

    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_key_load = kl;
    bus.in_key      = key;
    bus.in_block    = blk;
    @(negedge clk);
    chk("req_in_ready", bus.in_ready, 1'b1);
    T = cyc;

    nokey       = !kl && !m_kv;
    timeout_exp = !nokey && (mode >= 2);
    if (kl) begin m_key = key; m_kv = 1'b1; end
    if (nokey || timeout_exp) e = '{blk: '0, err: 1'b1};
    else                      e = '{blk: cipher(m_key, blk), err: 1'b0};
    exp_q.push_back(e);

    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_key   = rand256();
    bus.in_block = rand256()[127:0];

    nwr = 0; nstart = 0; ready_bad = 0; ov_cyc = -1; start_cyc = -1; d_cyc = -1; seen_low = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready) ready_bad++;
      if (bus.drv_write_en) begin
        chk("write_addr", bus.drv_write_addr, (kl ? 0 : 8) + nwr);
        nwr++;
      end
      if (bus.drv_start) begin nstart++; start_cyc = cyc; end
      if (start_cyc >= 0 && cyc > start_cyc && d_cyc < 0) begin
        if (!bus.drv_done) seen_low = 1;
        else if (seen_low) d_cyc = cyc;
      end
      if (bus.out_valid) begin ov_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    if (ov_cyc < 0) begin
      $display("FAIL out_valid_wait: got no out_valid, expected one within 100 cycles");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "job did not complete");
    end

    chk("busy_in_ready_low", ready_bad, 0);
    if (nokey) begin
      chk("nokey_ov_latency", ov_cyc - T, 1);
      chk("nokey_writes", nwr, 0);
      chk("nokey_starts", nstart, 0);
    end else begin
      chk("write_count", nwr, kl ? 12 : 4);
      chk("start_count", nstart, 1);
      chk("start_latency", start_cyc - T, kl ? 13 : 5);
      if (timeout_exp) chk("timeout_latency", ov_cyc - (start_cyc + 1), TMO);
      else             chk("done_to_out", ov_cyc - d_cyc, 5);
    end

    first = bus.out_block;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_out_stable", bus.out_block, first);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end

    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_out_in_ready", bus.in_ready, 1'b1);
    chk("post_out_valid", bus.out_valid, 1'b0);
    chk("key_valid", key_valid, m_kv);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_key_load = 1'b0;
    bus.in_key      = '0;
    bus.in_block    = '0;
    bus.out_ready   = 1'b0;
    reset           = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_write_en", bus.drv_write_en, 1'b0);
    chk("rst_start", bus.drv_start, 1'b0);
    chk("rst_out_block", bus.out_block, 128'd0);

    // No key after reset.
    run_job(1'b0, rand256(), rand256()[127:0], 0, 0);
    // Known-answer with key load, then cached key against a stale level done.
    run_job(1'b1, KAT_KEY, KAT_PT, 1, 0);
    run_job(1'b0, rand256(), KAT_PT, 1, 0);
    // Backpressure.
    run_job(1'b0, rand256(), rand256()[127:0], 0, 10);
    // Random traffic.
    for (int j = 0; j < 20; j++)
      run_job(1'($urandom_range(0, 1)), rand256(), rand256()[127:0],
              $urandom_range(0, 1), $urandom_range(0, 3));
    // Timeouts with done stuck low and stuck high.
    run_job(1'b0, rand256(), rand256()[127:0], 2, 0);
    run_job(1'b1, rand256(), rand256()[127:0], 3, 1);
    run_job(1'b0, rand256(), rand256()[127:0], 0, 0);

    // Reset during WAIT.
    stub_mode = 2;
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_key_load = 1'b1;
    bus.in_key      = rand256();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    begin
      bit got;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        if (bus.drv_start) got = 1;
      end
      chk("midjob_start_seen", got, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_kv = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_key_valid", key_valid, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    run_job(1'b0, rand256(), rand256()[127:0], 0, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_stream_sequencer.md
# aes_stream_sequencer

Sequencer that drives the AES-256 register-mapped driver on behalf of one streaming client. It accepts a 128-bit plaintext block, with an optional 256-bit key, over a valid/ready handshake. It performs the 32-bit register writes, pulses start and waits for done. It then reads the four ciphertext words back and presents the 128-bit result on a valid/ready output. The key stays cached in the driver, so the key writes are skipped when the client does not request a reload.

## Interface
- TIMEOUT, 255: maximum number of cycles spent in WAIT before the job is aborted with an error (≥2).
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  client request valid.
- in_ready  out  1  high only in IDLE.
- in_key_load  in  1  1: write in_key before the block; 0: reuse the cached key.
- in_key  in  256  key, word 0 = [255:224].
- in_block  in  128  plaintext, word 0 = [127:96].
- out_valid  out  1  result valid.
- out_ready  in  1  client accepts the result.
- out_block  out  128  ciphertext, word 0 = [127:96].
- out_error  out  1  qualifies out_valid: timeout, or no key loaded.
- key_valid  out  1  a key has been written since reset.
- busy  out  1  state ≠ IDLE.
- drv_data_in  out  32  driver write data.
- drv_write_addr  out  4  driver write address: 0–7 key, 8–11 plaintext.
- drv_write_en  out  1  driver write strobe.
- drv_start  out  1  single-cycle start pulse.
- drv_done  in  1  driver done flag; may be a level or a pulse.
- drv_read_addr  out  2  driver read select.
- drv_data_out  in  32  driver read data, combinational from drv_read_addr.

## Operation
- States: IDLE, WKEY, WPT, START, WAIT, READ, OUT.
- **IDLE**
  - in_ready=1.
  - On in_valid, capture in_key, in_block and in_key_load into internal registers.
  - in_key_load=1 → WKEY.
  - in_key_load=0 and key_valid=1 → WPT.
  - in_key_load=0 and key_valid=0 → OUT with out_error=1 and out_block=0; the driver is not touched.
- **WKEY** (8 cycles)
  - drv_write_en=1, drv_write_addr=0..7 in order.
  - drv_data_in = captured key word for that address.
  - After address 7, set key_valid → WPT.
- **WPT** (4 cycles)
  - drv_write_en=1, drv_write_addr=8..11, data = block words 0..3 → START.
- **START** (1 cycle)
  - drv_start=1.
  - Clear the done_low tracker and the timeout counter → WAIT.
- **WAIT**
  - done_low is set on any cycle with drv_done=0.
  - done_low=1 and drv_done=1 → READ. This rejects a stale level-high done left over from the previous job.
  - Counter increments every cycle. If TIMEOUT cycles elapse without done → OUT with out_error=1 and out_block=0.
  - A timeout does not clear key_valid.
- **READ** (4 cycles)
  - drv_read_addr=0..3.
  - drv_data_out is registered into out_block word k at the end of cycle k → OUT with out_error=0.
- **OUT**
  - out_valid=1; out_block and out_error are held stable.
  - On out_ready → IDLE.
- **Idle values:** drv_write_en, drv_start=0 outside their states; drv_write_addr, drv_data_in, drv_read_addr=0 when unused.
- **Reset** (in any state, including mid-job) → IDLE.
  - Every output is 0 except in_ready=1.
  - key_valid=0, because the driver's key register is cleared by the same reset.
- Timeout counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Request handshake at cycle T (in_valid & in_ready):
  - Key load: writes in T+1..T+12, drv_start at T+13, WAIT from T+14.
  - No key load: writes in T+1..T+4, drv_start at T+5, WAIT from T+6.
- Done sampled high in WAIT at cycle D: READ in D+1..D+4, out_valid from D+5.
- Missing-key error: out_valid at T+1.
- Output handshake at cycle E: IDLE and in_ready=1 at E+1. There is no same-cycle bypass of a new request.
- in_ready=0 from T+1 until E+1; a single job is in flight at a time.
- out_valid is never deasserted without out_ready.

## Test plan
- **Key load and encrypt.** Real driver. Key 000102…1e1f, block 00112233445566778899aabbccddeeff, in_key_load=1.
  - drv_write_en for 12 consecutive cycles, addresses 0..11 in order.
  - One drv_start pulse.
  - out_block=8ea2b7ca516745bfeafc49904b496089, out_error=0, key_valid=1.
- **Cached key.** Same block again with in_key_load=0.
  - Exactly 4 writes, addresses 8..11.
  - Same ciphertext; drv_start occurs 5 cycles after the request handshake.
- **No key after reset.** in_key_load=0 immediately after reset.
  - out_valid at T+1 with out_error=1 and out_block=0.
  - Zero drv_write_en and zero drv_start.
- **Backpressure.** out_ready held low for 10 cycles.
  - out_valid held, out_block stable, in_ready=0 throughout.
  - in_ready=1 the cycle after out_ready rises.
- **Timeout.** TIMEOUT=16, stub driver with drv_done stuck at 0.
  - out_valid with out_error=1 exactly 16 cycles after WAIT entry.
  - key_valid stays 1.
  - With drv_done stuck at 1 instead, the same timeout occurs, because done_low is never set.
- **Reset mid-job.** Assert reset during WAIT.
  - Next cycle: busy=0, out_valid=0, key_valid=0, in_ready=1.
  - A following in_key_load=0 request returns an error response.
